// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: states, opcode/funct constants and control encodings for mc_control_unit
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEX, S_RTWB,
    S_ADDIEX, S_SLTIEX, S_ITWB, S_BEQ, S_JUMP, S_JAL, S_JR, S_HALT
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_A      = 2'b11;
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: R-type funct to ALU operation; unknown functs fall back to ADD
module alu_op_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op
);
  always_comb
    alu_op = (func == FN_SUB) ? ALU_SUB :
             (func == FN_AND) ? ALU_AND :
             (func == FN_OR)  ? ALU_OR  :
             (func == FN_SLT) ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS control FSM; all outputs forced to 0 while rst is high.
// MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap to HALT and set a sticky illegal flag.
module mc_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPC,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCen,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       regWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       illegal
);
  state_t state, nxt, dec_nxt;
  logic [2:0] alu_rt;
  alu_op_decoder u_dec (.func(func), .alu_op(alu_rt));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILL_NXT = S_HALT;
  logic ill_q;
  always_ff @(posedge clk)
    if (rst) ill_q <= 1'b0;
    else if (state == S_DECODE && dec_nxt == S_HALT) ill_q <= 1'b1;
  assign illegal = ill_q & ~rst;
`else
  localparam state_t ILL_NXT = S_FETCH;
  assign illegal = 1'b0;
`endif
  always_comb
    dec_nxt = (OPC == OP_LW || OPC == OP_SW) ? S_MEMADR :
              (OPC == OP_RTYPE) ? ((func == FN_JR) ? S_JR : S_RTEX) :
              (OPC == OP_BEQ)  ? S_BEQ    :
              (OPC == OP_ADDI) ? S_ADDIEX :
              (OPC == OP_SLTI) ? S_SLTIEX :
              (OPC == OP_J)    ? S_JUMP   :
              (OPC == OP_JAL)  ? S_JAL    : ILL_NXT;
  always_ff @(posedge clk)
    if (rst) state <= S_FETCH;
    else state <= nxt;
  always_comb begin
    case (state)
      S_FETCH:            nxt = S_DECODE;
      S_DECODE:           nxt = dec_nxt;
      S_MEMADR:           nxt = (OPC == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:            nxt = S_MEMWB;
      S_RTEX:             nxt = S_RTWB;
      S_ADDIEX, S_SLTIEX: nxt = S_ITWB;
      S_HALT:             nxt = S_HALT;
      default:            nxt = S_FETCH;
    endcase
  end
  always_comb begin
    PCen = 1'b0;
    IorD = 1'b0;
    memRead = 1'b0;
    memWrite = 1'b0;
    IRWrite = 1'b0;
    regWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_B;
    ALUOperation = 3'b000;
    PCSrc = PC_ALU;
    regDst = DST_RT;
    memToReg = M2R_ALU;
    if (!rst) begin
      ALUOperation = ALU_ADD;
      case (state)
        S_FETCH:  begin memRead = 1'b1; IRWrite = 1'b1; ALUSrcB = SRCB_4; PCen = 1'b1; end
        S_DECODE: ALUSrcB = SRCB_IMMSH;
        S_MEMADR, S_ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
        S_SLTIEX: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; ALUOperation = ALU_SLT; end
        S_MEMRD:  begin IorD = 1'b1; memRead = 1'b1; end
        S_MEMWB:  begin regWrite = 1'b1; memToReg = M2R_MDR; end
        S_MEMWR:  begin IorD = 1'b1; memWrite = 1'b1; end
        S_RTEX:   begin ALUSrcA = 1'b1; ALUOperation = alu_rt; end
        S_RTWB:   begin regWrite = 1'b1; regDst = DST_RD; end
        S_ITWB:   regWrite = 1'b1;
        S_BEQ:    begin ALUSrcA = 1'b1; ALUOperation = ALU_SUB; PCSrc = PC_ALUOUT; PCen = zero; end
        S_JUMP:   begin PCSrc = PC_JUMP; PCen = 1'b1; end
        S_JAL:    begin PCSrc = PC_JUMP; PCen = 1'b1; regWrite = 1'b1; regDst = DST_RA; memToReg = M2R_PC; end
        S_JR:     begin PCSrc = PC_A; PCen = 1'b1; end
        default:  ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed check of mc_control_unit output vectors per state
module tb_mc_control_unit;
  logic clk = 1'b0, rst, zero;
  logic [5:0] OPC, func;
  logic PCen, IorD, memRead, memWrite, IRWrite, regWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSrc, regDst, memToReg;
  logic [2:0] ALUOperation;
  logic [18:0] outv;
  int total = 0, bad = 0;
  mc_control_unit dut (
    .clk(clk), .rst(rst), .OPC(OPC), .func(func), .zero(zero),
    .PCen(PCen), .IorD(IorD), .memRead(memRead), .memWrite(memWrite),
    .IRWrite(IRWrite), .regWrite(regWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOperation(ALUOperation), .PCSrc(PCSrc), .regDst(regDst),
    .memToReg(memToReg), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign outv = {PCen, IorD, memRead, memWrite, IRWrite, regWrite, ALUSrcA,
                 ALUSrcB, ALUOperation, PCSrc, regDst, memToReg, illegal};
  // field order: PCen IorD memRead memWrite IRWrite regWrite ALUSrcA | ALUSrcB | ALUOp | PCSrc | regDst | memToReg | illegal
  localparam logic [18:0] E_ZERO   = '0;
  localparam logic [18:0] E_FETCH  = {7'b1010100, 2'b01, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_DECODE = {7'b0000000, 2'b11, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_MEMADR = {7'b0000001, 2'b10, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_MEMRD  = {7'b0110000, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_MEMWB  = {7'b0000010, 2'b00, 3'b010, 2'b00, 2'b00, 2'b01, 1'b0};
  localparam logic [18:0] E_MEMWR  = {7'b0101000, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_RTSUB  = {7'b0000001, 2'b00, 3'b110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_RTSLT  = {7'b0000001, 2'b00, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_RTWB   = {7'b0000010, 2'b00, 3'b010, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [18:0] E_ADDIEX = {7'b0000001, 2'b10, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_ITWB   = {7'b0000010, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_BEQ1   = {7'b1000001, 2'b00, 3'b110, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_BEQ0   = {7'b0000001, 2'b00, 3'b110, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_JAL    = {7'b1000010, 2'b00, 3'b010, 2'b10, 2'b10, 2'b10, 1'b0};
  localparam logic [18:0] E_JR     = {7'b1000000, 2'b00, 3'b010, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [18:0] E_HALT   = {7'b0000000, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 1'b1};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [18:0] exp);
    total++;
    assert (outv === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, outv, exp);
    end
  endtask
  initial begin
    rst = 1'b1; OPC = 6'b0; func = 6'b0; zero = 1'b0;
    step(); step();
    chk("reset_outputs", E_ZERO);
    rst = 1'b0; #1;
    chk("first_fetch", E_FETCH);
    OPC = 6'b100011;
    step(); chk("lw_decode", E_DECODE);
    step(); chk("lw_memadr", E_MEMADR);
    step(); chk("lw_memrd", E_MEMRD);
    step(); chk("lw_memwb", E_MEMWB);
    step(); chk("lw_fetch_cycle6", E_FETCH);
    OPC = 6'b000000; func = 6'b100010;
    step(); chk("sub_decode", E_DECODE);
    step(); chk("sub_rtex", E_RTSUB);
    step(); chk("sub_rtwb", E_RTWB);
    step(); chk("sub_fetch", E_FETCH);
    func = 6'b101010;
    step(); step(); chk("slt_rtex", E_RTSLT);
    step(); step(); chk("slt_fetch", E_FETCH);
    OPC = 6'b001000;
    step(); step(); chk("addi_ex", E_ADDIEX);
    step(); chk("addi_itwb", E_ITWB);
    step(); chk("addi_fetch", E_FETCH);
    OPC = 6'b000100; zero = 1'b1;
    step(); step(); chk("beq_taken", E_BEQ1);
    step(); chk("beq_taken_fetch", E_FETCH);
    zero = 1'b0;
    step(); step(); chk("beq_not_taken", E_BEQ0);
    zero = 1'b1; #1;
    chk("beq_zero_mealy", E_BEQ1);
    zero = 1'b0;
    step(); chk("beq_nt_fetch", E_FETCH);
    OPC = 6'b000011;
    step(); step(); chk("jal", E_JAL);
    step(); chk("jal_fetch", E_FETCH);
    OPC = 6'b000000; func = 6'b001000;
    step(); step(); chk("jr", E_JR);
    step(); chk("jr_fetch", E_FETCH);
    OPC = 6'b101011;
    step(); chk("sw_decode", E_DECODE);
    step(); chk("sw_memadr", E_MEMADR);
    step(); chk("sw_memwr", E_MEMWR);
    step(); chk("sw_fetch", E_FETCH);
    step(); step(); step();
    rst = 1'b1; #1;
    chk("rst_in_memwr", E_ZERO);
    step(); chk("rst_held", E_ZERO);
    rst = 1'b0; #1;
    chk("fetch_after_rst", E_FETCH);
    OPC = 6'b111111;
    step(); chk("ill_decode", E_DECODE);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    step(); chk("ill_halt", E_HALT);
    step(); chk("ill_halt_held", E_HALT);
    rst = 1'b1; #1;
    chk("ill_rst", E_ZERO);
    step();
    rst = 1'b0; #1;
    chk("ill_cleared", E_FETCH);
`else
    step(); chk("ill_nop_fetch", E_FETCH);
    step(); step(); chk("ill_nop_again", E_FETCH);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control FSM that drives the single-memory MIPS datapath. It consumes the instruction fields latched by the IR (opcode, funct) and the ALU `zero` flag. Each cycle it produces every datapath control strobe and mux select, sequencing fetch, decode, execute, memory and write-back over 3–5 cycles per instruction. It sits directly beside the datapath inside the top-level processor.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `OPC` in 6: IR[31:26].
- `func` in 6: IR[5:0].
- `zero` in 1: ALU result == 0, combinational from datapath.
- `PCen` out 1: PC register load enable.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memRead` out 1: memory read strobe.
- `memWrite` out 1: memory write strobe, takes effect on the clock edge.
- `IRWrite` out 1: IR load enable.
- `regWrite` out 1: register-file write enable.
- `ALUSrcA` out 1: ALU A input select; 0 = PC, 1 = A register.
- `ALUSrcB` out 2: ALU B input select; 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `ALUOperation` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `PCSrc` out 2: next-PC select; 00 = ALUResult, 01 = ALUOut, 10 = {PC[31:28], imm26, 00}, 11 = A.
- `regDst` out 2: write-register select; 00 = rt, 01 = rd, 10 = $31.
- `memToReg` out 2: write-data select; 00 = ALUOut, 01 = MDR, 10 = PC.
- `illegal` out 1: sticky illegal-opcode flag (see Configuration).

## Operation
- Supported opcodes:
  - R-type 000000 with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 001000 jr.
  - lw 100011, sw 101011, beq 000100, addi 001000, slti 001010, j 000010, jal 000011.
- Outputs are a Moore decode of the state, except `PCen` in BEQ. All outputs default to 0 (ALUOperation default 010) unless listed.
- FETCH: memRead=1, IRWrite=1, ALUSrcB=01, ADD, PCSrc=00, PCen=1. Next state DECODE.
- DECODE: ALUSrcB=11, ADD (ALUOut gets the branch target).
  - lw/sw → MEMADR; R-type with funct jr → JR; other R-type → RTEX.
  - beq → BEQ; addi → ADDIEX; slti → SLTIEX; j → JUMP; jal → JAL.
  - Anything else → illegal handling.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, memRead=1. Next state MEMWB.
- MEMWB: regWrite=1, regDst=00, memToReg=01. Next state FETCH.
- MEMWR: IorD=1, memWrite=1. Next state FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUOperation from funct. Next state RTWB.
- RTWB: regWrite=1, regDst=01, memToReg=00. Next state FETCH.
- ADDIEX / SLTIEX: ALUSrcA=1, ALUSrcB=10, ADD / SLT. Next state ITWB.
- ITWB: regWrite=1, regDst=00, memToReg=00. Next state FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCen=zero (Mealy). Next state FETCH.
- JUMP: PCSrc=10, PCen=1. Next state FETCH.
- JAL: PCSrc=10, PCen=1, regWrite=1, regDst=10, memToReg=10. $31 receives the already-incremented PC, sampled before the same edge updates PC. Next state FETCH.
- JR: PCSrc=11, PCen=1. Next state FETCH.
- R-type with an unlisted funct: RTEX uses ADD; it is not treated as illegal.

## Timing
- CPI: lw 5; sw, R-type, addi, slti 4; beq, j, jal, jr 3.
- While `rst`=1, every output is 0 (combinationally gated), including `PCen` and `memWrite`. The state becomes FETCH at the next rising edge. Reset mid-instruction abandons the instruction with no partial write-back.
- The first cycle after `rst` falls is FETCH.
- `OPC` and `func` are sampled only in DECODE, RTEX and MEMADR. They are stable because IRWrite is asserted only in FETCH.
- `zero` is used only in BEQ and must settle within that cycle.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE moves to HALT and sets `illegal`=1.
  - HALT holds all strobes at 0 until `rst`.
  - `illegal` is cleared only by `rst`.
- Not defined:
  - An illegal opcode goes from DECODE to FETCH (executes as a NOP; PC is already +4).
  - HALT does not exist; `illegal` is tied to 0.

## Structure
- Package `mc_ctrl_pkg` holds:
  - The state enum.
  - Opcode and funct constants.
  - ALUOperation codes.
  - The ALUSrcB, PCSrc, regDst and memToReg select encodings.
- One sub-module, `alu_op_decoder`: combinational funct-to-ALUOperation mapping, used only in RTEX.

## Test plan
- Reset, then lw (OPC 100011): states FETCH→DECODE→MEMADR→MEMRD→MEMWB. MEMRD has IorD=1, memRead=1. MEMWB has regWrite=1, memToReg=01. FETCH recurs on cycle 6.
- R-type sub (func 100010): RTEX outputs ALUOperation=110, ALUSrcA=1, ALUSrcB=00. RTWB outputs regDst=01. Instruction takes 4 cycles.
- beq: zero=1 in BEQ gives PCen=1, PCSrc=01. Repeat with zero=0: PCen=0. Both take 3 cycles.
- jal: JAL cycle shows PCen=1, PCSrc=10, regWrite=1, regDst=10, memToReg=10. jr (func 001000): PCSrc=11, PCen=1.
- Assert rst during MEMWR: all outputs 0 in that cycle, memWrite never pulses, state is FETCH after release.
- OPC 111111: with macro, HALT is reached, `illegal`=1 and stays until rst. Without macro, FETCH follows DECODE and `illegal`=0.
